// File: rtl/ysyx_210184_pipe_ctrl_pkg.sv
// ysyx_210184_pipe_ctrl_pkg: shared bus width, FSM state encoding and sizing helper for the pipeline controller
package ysyx_210184_pipe_ctrl_pkg;
  localparam int REG_BUS = 64;
  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;
  function automatic int flw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/ysyx_210184_pipe_ctrl_if.sv
// ysyx_210184_pipe_ctrl_if: hazard/stall/flush bundle between pipeline (master) and controller (slave)
interface ysyx_210184_pipe_ctrl_if #(parameter int CNT_W = 32);
  import ysyx_210184_pipe_ctrl_pkg::*;
  logic [4:0]         id_rs1_i;
  logic [4:0]         id_rs2_i;
  logic               id_use_rs1_i;
  logic               id_use_rs2_i;
  logic               ex_load_i;
  logic [4:0]         ex_rd_i;
  logic               ex_redirect_i;
  logic [REG_BUS-1:0] ex_target_i;
  logic               mem_req_i;
  logic               mem_ready_i;
  logic               stall_mem_o;
  logic               stall_exe_o;
  logic               flush_o;
  logic               redirect_valid_o;
  logic [REG_BUS-1:0] redirect_pc_o;
  logic               busy_o;
  logic [CNT_W-1:0]   stall_cnt_o;
  logic [CNT_W-1:0]   flush_cnt_o;
  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_load_i, ex_rd_i,
           ex_redirect_i, ex_target_i, mem_req_i, mem_ready_i,
    input  stall_mem_o, stall_exe_o, flush_o, redirect_valid_o, redirect_pc_o,
           busy_o, stall_cnt_o, flush_cnt_o
  );
  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_load_i, ex_rd_i,
           ex_redirect_i, ex_target_i, mem_req_i, mem_ready_i,
    output stall_mem_o, stall_exe_o, flush_o, redirect_valid_o, redirect_pc_o,
           busy_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/ysyx_210184_hazard_det.sv
// ysyx_210184_hazard_det: combinational load-use compare (EXE load rd vs ID rs1/rs2, x0 never hazards)
module ysyx_210184_hazard_det (
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic       i_ex_load,
  input  logic [4:0] i_ex_rd,
  output logic       o_luse
);
  assign o_luse = i_ex_load & (i_ex_rd != 5'd0) &
                  ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) | (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));
endmodule

// File: rtl/ysyx_210184_pipe_ctrl.sv
// ysyx_210184_pipe_ctrl: hazard/flush sequencer; ports clk, rst (sync high), bus (slave: hazard inputs in, stall/flush/redirect/counters out)
module ysyx_210184_pipe_ctrl
  import ysyx_210184_pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_210184_pipe_ctrl_if.slave bus
);
  localparam int FL_W = flw(FLUSH_CYCLES);
  state_t             r_state, w_state_nx;
  logic [FL_W-1:0]    r_flush_left, w_flush_left_nx;
  logic               r_luse_done, r_redirect_valid;
  logic [REG_BUS-1:0] r_redirect_pc;
  logic [CNT_W-1:0]   r_stall_cnt, r_flush_cnt;
  logic               w_luse, w_stall_mem, w_stall_exe, w_flush, w_accept;
  ysyx_210184_hazard_det u_hazard_det (
    .i_id_rs1     (bus.id_rs1_i),
    .i_id_rs2     (bus.id_rs2_i),
    .i_id_use_rs1 (bus.id_use_rs1_i),
    .i_id_use_rs2 (bus.id_use_rs2_i),
    .i_ex_load    (bus.ex_load_i),
    .i_ex_rd      (bus.ex_rd_i),
    .o_luse       (w_luse)
  );
  // a frozen bus freezes everything; a redirect wins over a load-use bubble and restarts any flush in progress
  always_comb begin
    w_stall_mem     = bus.mem_req_i & ~bus.mem_ready_i;
    w_flush         = r_state == S_FLUSH;
    w_accept        = bus.ex_redirect_i & ~w_stall_mem;
    w_stall_exe     = ~w_flush & w_luse & ~r_luse_done & ~bus.ex_redirect_i & ~w_stall_mem;
    w_state_nx      = w_stall_mem ? r_state :
                      (w_accept | (w_flush & (r_flush_left != '0))) ? S_FLUSH : S_RUN;
    w_flush_left_nx = w_stall_mem ? r_flush_left :
                      w_accept ? FL_W'(FLUSH_CYCLES - 1) :
                      (r_flush_left != '0) ? r_flush_left - FL_W'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_RUN;
      r_flush_left     <= '0;
      r_luse_done      <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_stall_cnt      <= '0;
      r_flush_cnt      <= '0;
    end else begin
      r_state          <= w_state_nx;
      r_flush_left     <= w_flush_left_nx;
      r_luse_done      <= w_stall_mem ? r_luse_done : w_stall_exe;
      r_redirect_valid <= w_accept;
      r_redirect_pc    <= w_accept ? bus.ex_target_i : r_redirect_pc;
      r_stall_cnt      <= r_stall_cnt + CNT_W'(w_stall_mem | w_stall_exe);
      r_flush_cnt      <= r_flush_cnt + CNT_W'(w_flush);
    end
  end
  assign bus.stall_mem_o      = w_stall_mem;
  assign bus.stall_exe_o      = w_stall_exe;
  assign bus.flush_o          = w_flush;
  assign bus.redirect_valid_o = r_redirect_valid;
  assign bus.redirect_pc_o    = r_redirect_pc;
  assign bus.busy_o           = r_state != S_RUN;
  assign bus.stall_cnt_o      = r_stall_cnt;
  assign bus.flush_cnt_o      = r_flush_cnt;
endmodule
